// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolution: evaluates RV32I branch conditions, flags
// mispredicts, drives the wrong-path kill window and keeps statistics.
module ex_branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_branch,
    input  logic [2:0]       ID_funct3,
    input  logic             ID_pred_take,
    input  logic [31:0]      ID_rs1_val,
    input  logic [31:0]      ID_rs2_val,
    input  logic             EX_stall,
    input  logic             stat_clear,
    output logic             EX_branch,
    output logic             EX_zero,
    output logic             EX_flush,
    output logic             EX_kill,
    output logic             EX_illegal,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int KW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [KW-1:0] KILL_INIT = KW'(FLUSH_CYCLES - 1);

    typedef struct packed {
        logic        valid;
        logic [2:0]  funct3;
        logic        pred_take;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } ex_reg_t;

    ex_reg_t         ex_q, ex_d;
    logic [KW-1:0]   kill_q, kill_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] mp_q, mp_d;

    logic taken;
    logic illegal;
    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (ex_q.rs1 == ex_q.rs2);
    assign lt_s = ($signed(ex_q.rs1) < $signed(ex_q.rs2));
    assign lt_u = (ex_q.rs1 < ex_q.rs2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        unique case (ex_q.funct3)
            3'b000: taken = eq;
            3'b001: taken = ~eq;
            3'b100: taken = lt_s;
            3'b101: taken = ~lt_s;
            3'b110: taken = lt_u;
            3'b111: taken = ~lt_u;
            3'b010,
            3'b011: illegal = 1'b1;
        endcase
    end

    assign EX_branch  = ex_q.valid & ~EX_stall;
    assign EX_zero    = EX_branch & taken;
    assign EX_illegal = EX_branch & illegal;
    assign EX_flush   = EX_branch & (taken != ex_q.pred_take);
    assign EX_kill    = EX_flush | (kill_q != '0);

    // Anything entering during a kill cycle is wrong-path and dropped.
    always_comb begin
        ex_d = ex_q;
        if (!EX_stall) begin
            ex_d.valid     = ID_branch & ~EX_kill;
            ex_d.funct3    = ID_funct3;
            ex_d.pred_take = ID_pred_take;
            ex_d.rs1       = ID_rs1_val;
            ex_d.rs2       = ID_rs2_val;
        end
    end

    always_comb begin
        kill_d = kill_q;
        if (EX_flush) begin
            kill_d = KILL_INIT;
        end else if ((kill_q != '0) && !EX_stall) begin
            kill_d = kill_q - 1'b1;
        end
    end

    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (stat_clear) begin
            br_d = '0;
            mp_d = '0;
        end else begin
            if (EX_branch && (br_q != '1)) br_d = br_q + 1'b1;
            if (EX_flush && (mp_q != '1))  mp_d = mp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q   <= '0;
            kill_q <= '0;
            br_q   <= '0;
            mp_q   <= '0;
        end else begin
            ex_q   <= ex_d;
            kill_q <= kill_d;
            br_q   <= br_d;
            mp_q   <= mp_d;
        end
    end

    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;

    a_no_flush_in_kill : assert property (
        @(posedge clk) disable iff (!reset)
        !(EX_flush && (kill_q != '0))
    );

endmodule
